// File: rtl/pwm_duty_ramp_ctrl.sv
// ============================================================================
// pwm_duty_ramp_ctrl
// ----------------------------------------------------------------------------
// Produces the 11-bit duty word for a free-running 11-bit PWM generator
// (counter 0..2047, output high while duty > count).
//
// The upstream controller delivers target duties over a valid/ready
// handshake. Each accepted target is clipped to DUTY_MAX. The applied duty
// slews toward the target by at most STEP per PWM period. It only changes on
// the edge where pwm_wrap is high, so the new value first shows at count 0 and
// no PWM period is ever truncated.
//
// Deasserting enable ramps the duty down to 0 (soft-stop) and then idles. A
// fault forces the duty to 0 on the very next edge.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   pwm_wrap      1-cycle pulse while the PWM counter holds 2047
//   enable        level: 1 = run, 0 = ramp down and idle
//   tgt_duty      requested duty (11 bits)
//   tgt_vld       tgt_duty is valid
//   tgt_rdy       a target can be accepted this cycle
//   fault         level: forces immediate shutdown
//   clr_fault     1-cycle pulse: leaves FAULT when fault=0 and enable=0
//   duty          registered duty word to the PWM generator
//   at_target     in HOLD with duty equal to the applied target
//   busy          ramping up/down (RAMP or STOP)
//   fault_active  in FAULT
// ============================================================================
module pwm_duty_ramp_ctrl #(
    parameter logic [10:0] STEP     = 11'd16,   // max duty change per PWM period, nonzero
    parameter logic [10:0] DUTY_MAX = 11'd2000  // clip applied to accepted targets
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_wrap,
    input  logic        enable,
    input  logic [10:0] tgt_duty,
    input  logic        tgt_vld,
    output logic        tgt_rdy,
    input  logic        fault,
    input  logic        clr_fault,
    output logic [10:0] duty,
    output logic        at_target,
    output logic        busy,
    output logic        fault_active
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_STOP  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] duty_q,  duty_d;
    logic [10:0] tgt_q,   tgt_d;

    logic [10:0] tgt_clip;
    logic        accept;

    // Move cur one slew step toward tgt. Distances up to STEP land exactly on
    // tgt, so there is never an overshoot. Since tgt never exceeds DUTY_MAX,
    // cur + STEP cannot wrap the 11-bit range when tgt > cur.
    function automatic logic [10:0] step_toward(input logic [10:0] cur,
                                                input logic [10:0] tgt);
        logic [10:0] diff;
        logic [10:0] res;
        diff = 11'd0;
        res  = cur;
        if (tgt > cur) begin
            diff = tgt - cur;
            res  = (diff > STEP) ? (cur + STEP) : tgt;
        end else if (tgt < cur) begin
            diff = cur - tgt;
            res  = (diff > STEP) ? (cur - STEP) : tgt;
        end
        return res;
    endfunction

    assign tgt_clip = (tgt_duty > DUTY_MAX) ? DUTY_MAX : tgt_duty;
    assign accept   = tgt_vld && tgt_rdy;

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: fault, then enable, then the wrap step.
    // The step always uses tgt_q (the value before any same-edge transfer), so
    // a target accepted on a wrap edge only affects the following wrap.
    // State decisions that compare against the target use tgt_d, so a transfer
    // on this edge is taken into account immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = accept ? tgt_clip : tgt_q;

        if (fault) begin
            state_d = ST_FAULT;
            duty_d  = 11'd0;
            tgt_d   = 11'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Targets are stored here but not applied until enabled.
                    duty_d = 11'd0;
                    if (enable) begin
                        state_d = (tgt_d != 11'd0) ? ST_RAMP : ST_HOLD;
                    end
                end

                // RAMP and HOLD share one rule set. In HOLD, duty_q == tgt_q,
                // so the wrap step is a no-op and the duty stays constant.
                ST_RAMP, ST_HOLD: begin
                    if (!enable) begin
                        // Soft-stop: the effective target becomes 0.
                        state_d = ST_STOP;
                        tgt_d   = 11'd0;
                    end else begin
                        if (pwm_wrap) begin
                            duty_d = step_toward(duty_q, tgt_q);
                        end
                        state_d = (duty_d == tgt_d) ? ST_HOLD : ST_RAMP;
                    end
                end

                ST_STOP: begin
                    tgt_d = 11'd0;
                    if (enable) begin
                        // Re-enable resumes ramping toward 0 and reopens the
                        // handshake so a new target can be accepted.
                        state_d = ST_RAMP;
                    end else begin
                        if (pwm_wrap) begin
                            duty_d = step_toward(duty_q, 11'd0);
                        end
                        if (duty_d == 11'd0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end

                ST_FAULT: begin
                    duty_d = 11'd0;
                    tgt_d  = 11'd0;
                    // Exit only with the machine safely disabled.
                    if (clr_fault && !enable) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    duty_d  = 11'd0;
                    tgt_d   = 11'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            duty_q  <= 11'd0;
            tgt_q   <= 11'd0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
        end
    end

    // Outputs are the duty register itself or decodes of registered state.
    assign duty         = duty_q;
    assign tgt_rdy      = (state_q == ST_IDLE) || (state_q == ST_RAMP) ||
                          (state_q == ST_HOLD);
    assign at_target    = (state_q == ST_HOLD) && (duty_q == tgt_q);
    assign busy         = (state_q == ST_RAMP) || (state_q == ST_STOP);
    assign fault_active = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// ============================================================================
// tb_pwm_duty_ramp_ctrl
// Table-driven directed sequences with hand-derived expectations, an
// asynchronous-reset sequence, then randomized stimulus compared every cycle
// against a behavioural model built from the slew/clip/mode rules.
// ============================================================================
module tb_pwm_duty_ramp_ctrl;

    localparam int STEP_I     = 16;
    localparam int DUTY_MAX_I = 2000;

    localparam int M_IDLE  = 0;
    localparam int M_RAMP  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_STOP  = 3;
    localparam int M_FAULT = 4;

    logic        clk;
    logic        rst_n;
    logic        pwm_wrap;
    logic        enable;
    logic [10:0] tgt_duty;
    logic        tgt_vld;
    logic        tgt_rdy;
    logic        fault;
    logic        clr_fault;
    logic [10:0] duty;
    logic        at_target;
    logic        busy;
    logic        fault_active;

    int n_checks;
    int n_err;

    pwm_duty_ramp_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_wrap     (pwm_wrap),
        .enable       (enable),
        .tgt_duty     (tgt_duty),
        .tgt_vld      (tgt_vld),
        .tgt_rdy      (tgt_rdy),
        .fault        (fault),
        .clr_fault    (clr_fault),
        .duty         (duty),
        .at_target    (at_target),
        .busy         (busy),
        .fault_active (fault_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------------
    typedef struct {
        int duty;
        int tgt;
        int mode;
    } mstate_t;

    mstate_t m;

    function automatic int clamp_move(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d > STEP_I)  d = STEP_I;
        if (d < -STEP_I) d = -STEP_I;
        return cur + d;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input bit en, input bit vld,
                                           input int td, input bit wr, input bit flt,
                                           input bit clr);
        mstate_t n;
        bit      open;
        n    = s;
        open = (s.mode == M_IDLE) || (s.mode == M_RAMP) || (s.mode == M_HOLD);
        if (vld && open) n.tgt = (td > DUTY_MAX_I) ? DUTY_MAX_I : td;
        if (flt) begin
            n.duty = 0;
            n.tgt  = 0;
            n.mode = M_FAULT;
        end else if (s.mode == M_IDLE) begin
            if (en) n.mode = (n.tgt != 0) ? M_RAMP : M_HOLD;
        end else if (s.mode == M_RAMP || s.mode == M_HOLD) begin
            if (!en) begin
                n.mode = M_STOP;
                n.tgt  = 0;
            end else begin
                if (wr) n.duty = clamp_move(s.duty, s.tgt);
                n.mode = (n.duty == n.tgt) ? M_HOLD : M_RAMP;
            end
        end else if (s.mode == M_STOP) begin
            if (en) n.mode = M_RAMP;
            else begin
                if (wr) n.duty = clamp_move(s.duty, 0);
                if (n.duty == 0) n.mode = M_IDLE;
            end
        end else begin
            if (clr && !en) n.mode = M_IDLE;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{duty: 0, tgt: 0, mode: M_IDLE};
        end else begin
            m <= model_next(m, enable, tgt_vld, int'(tgt_duty), pwm_wrap, fault, clr_fault);
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_duty, input bit e_rdy,
                           input bit e_at, input bit e_busy, input bit e_fa);
        chk({tag, " duty"},         int'(duty),         e_duty);
        chk({tag, " tgt_rdy"},      int'(tgt_rdy),      int'(e_rdy));
        chk({tag, " at_target"},    int'(at_target),    int'(e_at));
        chk({tag, " busy"},         int'(busy),         int'(e_busy));
        chk({tag, " fault_active"}, int'(fault_active), int'(e_fa));
    endtask

    task automatic drive(input bit en, input bit vld, input int td, input bit wr,
                         input bit flt, input bit clr);
        enable    = en;
        tgt_vld   = vld;
        tgt_duty  = 11'(td);
        pwm_wrap  = wr;
        fault     = flt;
        clr_fault = clr;
    endtask

    // ------------------------------------------------------------------------
    // Directed vectors: gap idle cycles (enable held, nothing else), then rep
    // edges with the row's inputs, then the expected outputs.
    // ------------------------------------------------------------------------
    typedef struct {
        bit en;
        bit vld;
        int tgt;
        bit wrap;
        bit flt;
        bit clr;
        int gap;
        int rep;
        int e_duty;
        bit e_rdy;
        bit e_at;
        bit e_busy;
        bit e_fa;
    } vec_t;

    vec_t tbl[$];
    vec_t post_rst[$];

    function automatic vec_t mk(input bit en, input bit vld, input int tgt, input bit wrap,
                                input bit flt, input bit clr, input int gap, input int rep,
                                input int ed, input bit er, input bit ea, input bit eb,
                                input bit ef);
        vec_t v;
        v = '{en: en, vld: vld, tgt: tgt, wrap: wrap, flt: flt, clr: clr, gap: gap,
              rep: rep, e_duty: ed, e_rdy: er, e_at: ea, e_busy: eb, e_fa: ef};
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        drive(v.en, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (v.gap) begin
            @(posedge clk);
            #1;
        end
        drive(v.en, v.vld, v.tgt, v.wrap, v.flt, v.clr);
        repeat (v.rep) begin
            @(posedge clk);
            #1;
        end
        drive(v.en, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        chk_all(tag, v.e_duty, v.e_rdy, v.e_at, v.e_busy, v.e_fa);
        $display("%s: en=%0b vld=%0b tgt=%0d wrap=%0b fault=%0b clr=%0b x%0d -> duty=%0d rdy=%0b at=%0b busy=%0b fa=%0b",
                 tag, v.en, v.vld, v.tgt, v.wrap, v.flt, v.clr, v.rep,
                 duty, tgt_rdy, at_target, busy, fault_active);
    endtask

    initial begin
        bit r_en;

        n_checks = 0;
        n_err    = 0;

        // Soft-start to 100, one wrap per 2048-cycle PWM period.
        tbl.push_back(mk(1, 1, 100, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0));
        for (int k = 1; k <= 7; k++) begin
            tbl.push_back(mk(1, 0, 0, 1, 0, 0, 2047, 1, (k < 7) ? 16 * k : 100,
                             1, k == 7, k != 7, 0));
        end
        // HOLD at 100, new target 40: 84,68,52,40.
        tbl.push_back(mk(1, 1, 40, 0, 0, 0, 3, 1,  100, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1,   84, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1,   68, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1,   52, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1,   40, 1, 1, 0, 0));
        // Held wrap steps every cycle: 40 -> 1990 in 122 steps (last partial).
        tbl.push_back(mk(1, 1, 1990, 0, 0, 0, 3, 1,   40, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 122,  1990, 1, 1, 0, 0));
        // 2047 clips to 2000; one wrap lands on it and it never goes higher.
        tbl.push_back(mk(1, 1, 2047, 0, 0, 0, 3, 1, 1990, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1,  2000, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 5,   2000, 1, 1, 0, 0));
        // Back down to 100: 119 wraps.
        tbl.push_back(mk(1, 1, 100, 0, 0, 0, 3, 1, 2000, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 119,  100, 1, 1, 0, 0));
        // Transfer 500 on a wrap edge: duty stays 100, next wrap gives 116.
        tbl.push_back(mk(1, 1, 500, 1, 0, 0, 15, 1, 100, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1,   116, 1, 0, 1, 0));
        // Soft-stop from 116: 100,84,...,4 then 0 and IDLE.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,    116, 0, 0, 1, 0));
        for (int k = 1; k <= 7; k++) begin
            tbl.push_back(mk(0, 0, 0, 1, 0, 0, 15, 1, 116 - 16 * k, 0, 0, 1, 0));
        end
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 15, 1,     0, 1, 0, 0, 0));
        // Fault at duty 64 mid-ramp, then the clr_fault rules.
        tbl.push_back(mk(1, 1, 200, 0, 0, 0, 3, 1,    0, 1, 0, 1, 0));
        for (int k = 1; k <= 4; k++) begin
            tbl.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1, 16 * k, 1, 0, 1, 0));
        end
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 5, 1,      0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1,      0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1,      0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 1,      0, 1, 0, 0, 0));
        // Target stored in IDLE is not applied until enable.
        tbl.push_back(mk(0, 1, 80, 1, 0, 0, 3, 1,     0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3, 1,      0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1,    16, 1, 0, 1, 0));

        // After the asynchronous reset: ramp 0 -> 50 again.
        post_rst.push_back(mk(1, 1, 50, 0, 0, 0, 3, 1,  0, 1, 0, 1, 0));
        post_rst.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1, 16, 1, 0, 1, 0));
        post_rst.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1, 32, 1, 0, 1, 0));
        post_rst.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1, 48, 1, 0, 1, 0));
        post_rst.push_back(mk(1, 0, 0, 1, 0, 0, 15, 1, 50, 1, 1, 0, 0));

        // Reset.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #1;
        chk_all("reset", 0, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_reset", 0, 1, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Asynchronous reset mid-ramp, between clock edges (now RAMP at 16).
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < post_rst.size(); i++) begin
            apply(post_rst[i], $sformatf("rerun%0d", i));
        end

        // Randomized stimulus against the model.
        r_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(47) == 0) r_en = ~r_en;
            drive(r_en,
                  $urandom_range(5) == 0,
                  ($urandom_range(3) == 0) ? int'($urandom_range(2047, 1900))
                                           : int'($urandom_range(400)),
                  $urandom_range(3) == 0,
                  $urandom_range(299) == 0,
                  $urandom_range(7) == 0);
            @(posedge clk);
            #1;
            chk_all($sformatf("rand%0d", c), m.duty,
                    (m.mode == M_IDLE) || (m.mode == M_RAMP) || (m.mode == M_HOLD),
                    (m.mode == M_HOLD) && (m.duty == m.tgt),
                    (m.mode == M_RAMP) || (m.mode == M_STOP),
                    m.mode == M_FAULT);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
